// File: rtl/gb_cmp_pkg.sv
// Shared types and default sizes for the Gaussian-blur output-stream scoreboard.
package gb_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } gb_state_e;

  localparam int unsigned GB_DATA_W = 8;
  localparam int unsigned GB_DEPTH  = 8;
  localparam int unsigned GB_CNT_W  = 32;

endpackage

// File: rtl/gb_cmp_fifo.sv
// Synchronous FIFO with registered full/empty flags; DEPTH must be a power of 2, >= 2.
module gb_cmp_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    wr_d    = do_push ? wr_q + PW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/gb_stream_cmp.sv
// Beat-by-beat comparator of the ILA and HLS output streams, each buffered in its own FIFO.
// Optional watchdog enabled by defining GB_STREAM_CMP_TIMEOUT_EN.
module gb_stream_cmp
  import gb_cmp_pkg::*;
#(
  parameter int unsigned DATA_W      = GB_DATA_W,
  parameter int unsigned DEPTH       = GB_DEPTH,
  parameter int unsigned CNT_W       = GB_CNT_W,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_pix,
  input  logic [DATA_W-1:0] ila_tdata,
  input  logic              ila_tvalid,
  output logic              ila_tready,
  input  logic [DATA_W-1:0] hls_tdata,
  input  logic              hls_tvalid,
  output logic              hls_tready,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  mis_idx,
  output logic [DATA_W-1:0] mis_ila,
  output logic [DATA_W-1:0] mis_hls,
  output logic              timeout
);

  gb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  num_pix_q, num_pix_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]  mis_idx_q, mis_idx_d;
  logic [DATA_W-1:0] mis_ila_q, mis_ila_d, mis_hls_q, mis_hls_d;
  logic              mismatch_q, mismatch_d;
  logic              ila_full, ila_empty, hls_full, hls_empty;
  logic [DATA_W-1:0] ila_head, hls_head;
  logic              run, ila_push, hls_push, cmp;

  assign run        = (state_q == RUN);
  assign ila_tready = run && !ila_full;
  assign hls_tready = run && !hls_full;
  assign ila_push   = ila_tvalid && ila_tready;
  assign hls_push   = hls_tvalid && hls_tready;
  assign cmp        = run && !ila_empty && !hls_empty;

  gb_cmp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ila_fifo (
    .clk(clk), .rst(rst), .push_i(ila_push), .pop_i(cmp), .wdata_i(ila_tdata),
    .rdata_o(ila_head), .full_o(ila_full), .empty_o(ila_empty)
  );

  gb_cmp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_hls_fifo (
    .clk(clk), .rst(rst), .push_i(hls_push), .pop_i(cmp), .wdata_i(hls_tdata),
    .rdata_o(hls_head), .full_o(hls_full), .empty_o(hls_empty)
  );

`ifdef GB_STREAM_CMP_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  // Watchdog not built; the expression keeps TIMEOUT_CYC referenced.
  assign timeout = (TIMEOUT_CYC == 0) && 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    num_pix_d   = num_pix_q;
    match_cnt_d = match_cnt_q;
    mis_idx_d   = mis_idx_q;
    mis_ila_d   = mis_ila_q;
    mis_hls_d   = mis_hls_q;
    mismatch_d  = mismatch_q;
`ifdef GB_STREAM_CMP_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_pix_d   = cfg_num_pix;
          match_cnt_d = '0;
          mis_idx_d   = '0;
          mis_ila_d   = '0;
          mis_hls_d   = '0;
`ifdef GB_STREAM_CMP_TIMEOUT_EN
          wd_d        = '0;
`endif
          state_d     = (cfg_num_pix == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cmp) begin
          if (ila_head == hls_head) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
            if (match_cnt_d == num_pix_q) state_d = DONE;
          end else begin
            state_d    = FAIL;
            mismatch_d = 1'b1;
            mis_idx_d  = match_cnt_q;
            mis_ila_d  = ila_head;
            mis_hls_d  = hls_head;
          end
        end
`ifdef GB_STREAM_CMP_TIMEOUT_EN
        if (cmp) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(TIMEOUT_CYC)) begin
            state_d   = FAIL;
            timeout_d = 1'b1;
          end
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      num_pix_q   <= '0;
      match_cnt_q <= '0;
      mis_idx_q   <= '0;
      mis_ila_q   <= '0;
      mis_hls_q   <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_pix_q   <= num_pix_d;
      match_cnt_q <= match_cnt_d;
      mis_idx_q   <= mis_idx_d;
      mis_ila_q   <= mis_ila_d;
      mis_hls_q   <= mis_hls_d;
      mismatch_q  <= mismatch_d;
    end
  end

`ifdef GB_STREAM_CMP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign match_cnt = match_cnt_q;
  assign done      = (state_q == DONE);
  assign mismatch  = mismatch_q;
  assign mis_idx   = mis_idx_q;
  assign mis_ila   = mis_ila_q;
  assign mis_hls   = mis_hls_q;

endmodule
